// File: rtl/int_sched_if.sv
// int_sched_if: CPU-side interrupt, handshake and config bus for int_sched
interface int_sched_if #(parameter int NSRC = 4);
  localparam int IW = $clog2(NSRC);
  logic [NSRC-1:0] irq_in;
  logic            stall_f;
  logic            branch_stall;
  logic            int_ack;
  logic            rti;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [NSRC-1:0] cfg_data;
  logic [NSRC-1:0] int_req;
  logic [IW-1:0]   int_id;
  logic            in_service;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] lost;
  logic [2:0]      state;
  modport master (
    output irq_in, stall_f, branch_stall, int_ack, rti, cfg_we, cfg_addr, cfg_data,
    input  int_req, int_id, in_service, pending, mask, lost, state
  );
  modport slave (
    input  irq_in, stall_f, branch_stall, int_ack, rti, cfg_we, cfg_addr, cfg_data,
    output int_req, int_id, in_service, pending, mask, lost, state
  );
endinterface

// File: rtl/int_sched.sv
// int_sched: edge-captured pending interrupts, round-robin arbitration and req/ack/rti sequencing
module int_sched #(
  parameter int NSRC  = 4,
  parameter int DRAIN = 2
) (
  input logic        clk,
  input logic        rst_n,
  int_sched_if.slave bus
);
  localparam int IW = $clog2(NSRC);
  typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, SERVICE = 3'd2, DRAIN_S = 3'd3} state_t;
  state_t          state_q;
  logic [NSRC-1:0] irq_q, pend_q, pend_d, mask_q, mask_d, lost_q, lost_d, req_q;
  logic [NSRC-1:0] evt, ack_clr, set_v, clr_v, elig;
  logic [IW-1:0]   id_q, ptr_q, win;
  logic [3:0]      cnt_q;
  logic            svc_q;
  // Next-state of the pending/lost/mask bits: sets beat clears, and an ack clear hides the overrun
  always_comb begin
    evt     = bus.irq_in & ~irq_q;
    ack_clr = (state_q == REQ && bus.int_ack) ? NSRC'(1) << id_q : '0;
    set_v   = evt | ((bus.cfg_we && bus.cfg_addr == 2'd3) ? bus.cfg_data : '0);
    clr_v   = ack_clr | ((bus.cfg_we && bus.cfg_addr == 2'd2) ? bus.cfg_data : '0);
    pend_d  = (pend_q & ~clr_v) | set_v;
    lost_d  = (lost_q & ~((bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_data : '0)) | (evt & pend_q & ~ack_clr);
    mask_d  = (bus.cfg_we && bus.cfg_addr == 2'd0) ? bus.cfg_data : mask_q;
    elig    = pend_q & ~mask_q;
  end
  // Round-robin winner: first eligible index at or above the pointer, wrapping
  always_comb begin
    win = '0;
    for (int k = NSRC - 1; k >= 0; k--)
      if (elig[(int'(ptr_q) + k) % NSRC]) win = IW'((int'(ptr_q) + k) % NSRC);
  end
  // Edge capture and the software-visible pending/mask/lost registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      pend_q <= '0;
      mask_q <= '1;
      lost_q <= '0;
    end else begin
      irq_q  <= bus.irq_in;
      pend_q <= pend_d;
      mask_q <= mask_d;
      lost_q <= lost_d;
    end
  end
  // Request/service/drain sequencer; a request once issued is committed until acked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      id_q    <= '0;
      svc_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (|elig && !bus.stall_f && !bus.branch_stall) begin
          state_q <= REQ;
          id_q    <= win;
          req_q   <= NSRC'(1) << win;
        end
        REQ: if (bus.int_ack) begin
          state_q <= SERVICE;
          req_q   <= '0;
          svc_q   <= 1'b1;
        end
        SERVICE: if (bus.rti) begin
          state_q <= DRAIN_S;
          svc_q   <= 1'b0;
          ptr_q   <= IW'((int'(id_q) + 1) % NSRC);
          cnt_q   <= 4'(DRAIN);
        end
        DRAIN_S: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= (cnt_q == 4'd1) ? IDLE : DRAIN_S;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.int_req    = req_q;
  assign bus.int_id     = id_q;
  assign bus.in_service = svc_q;
  assign bus.pending    = pend_q;
  assign bus.mask       = mask_q;
  assign bus.lost       = lost_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: scoreboarded random and directed test of int_sched against a behavioural model
module tb_int_sched;
  localparam int N  = 4;
  localparam int DR = 2;
  localparam int P_IDLE = 0, P_REQ = 1, P_SVC = 2, P_DRN = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [3:0] m_pend, m_mask, m_lost, m_prev, lvl;
  int m_ph, m_id, m_ptr, m_cnt;
  int_sched_if #(.NSRC(N)) bus();
  int_sched #(.NSRC(N), .DRAIN(DR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = 4'hf; m_lost = '0; m_prev = '0;
    m_ph = P_IDLE; m_id = 0; m_ptr = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  function automatic int pick(input logic [3:0] e, input int p);
    for (int k = 0; k < N; k++) if (e[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive(input logic [3:0] irq, input logic st, br, ack, rt, we, input logic [1:0] a, input logic [3:0] d);
    bus.irq_in = irq; bus.stall_f = st; bus.branch_stall = br; bus.int_ack = ack;
    bus.rti = rt; bus.cfg_we = we; bus.cfg_addr = a; bus.cfg_data = d;
  endtask

  // One clock: drive at negedge, advance the model as the posedge would, compare at the next negedge
  task automatic step(input logic [3:0] irq, input logic st, br, ack, rt, we, input logic [1:0] a, input logic [3:0] d);
    logic [3:0] ev, ackc, elig;
    drive(irq, st, br, ack, rt, we, a, d);
    ev   = irq & ~m_prev;
    ackc = (m_ph == P_REQ && ack) ? 4'(1 << m_id) : 4'h0;
    elig = m_pend & ~m_mask;
    if (m_ph == P_IDLE && elig != 0 && !st && !br) begin
      m_id = pick(elig, m_ptr); m_ph = P_REQ; exp_q.push_back(m_id);
    end else if (m_ph == P_REQ && ack) m_ph = P_SVC;
    else if (m_ph == P_SVC && rt) begin
      m_ph = P_DRN; m_ptr = (m_id + 1) % N; m_cnt = DR;
    end else if (m_ph == P_DRN) begin
      m_cnt--;
      if (m_cnt == 0) m_ph = P_IDLE;
    end
    m_lost = (m_lost & ~((we && a == 2'd1) ? d : 4'h0)) | (ev & m_pend & ~ackc);
    m_pend = (m_pend & ~(ackc | ((we && a == 2'd2) ? d : 4'h0))) | ev | ((we && a == 2'd3) ? d : 4'h0);
    if (we && a == 2'd0) m_mask = d;
    m_prev = irq;
    @(posedge clk);
    @(negedge clk);
    chk("pending", bus.pending, m_pend);
    chk("lost", bus.lost, m_lost);
    chk("mask", bus.mask, m_mask);
    chk("in_service", bus.in_service, m_ph == P_SVC);
    chk("int_req", bus.int_req, m_ph == P_REQ ? 32'(1 << m_id) : 32'h0);
    if (m_ph == P_REQ || m_ph == P_SVC) chk("int_id", bus.int_id, m_id);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(lvl, 0, 0, 0, 0, 0, 2'd0, 4'h0);
  endtask

  task automatic wait_ph(input int ph);
    int n = 0;
    while (m_ph != ph && n < 40) begin idle(1); n++; end
    if (m_ph != ph) chk("phase_timeout", m_ph, ph);
  endtask

  task automatic serve();
    wait_ph(P_REQ);
    step(lvl, 0, 0, 1, 0, 0, 2'd0, 4'h0);
    idle(2);
    step(lvl, 0, 0, 0, 1, 0, 2'd0, 4'h0);
    wait_ph(P_IDLE);
  endtask

  // Monitor: every newly presented request must match the oldest predicted grant
  initial begin
    logic [3:0] prev;
    int e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.int_req != 0 && prev == 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant got %0h expected none", bus.int_req);
        end else begin
          e = exp_q.pop_front();
          chk("grant_req", bus.int_req, 32'(1 << e));
          chk("grant_id", bus.int_id, e);
        end
      end
      prev = bus.int_req;
    end
  end

  initial begin
    model_reset();
    lvl = '0;
    drive(0, 0, 0, 0, 0, 0, 2'd0, 4'h0);
    repeat (2) @(negedge clk);
    chk("rst_pending", bus.pending, 0);
    chk("rst_mask", bus.mask, 4'hf);
    chk("rst_lost", bus.lost, 0);
    chk("rst_req", bus.int_req, 0);
    chk("rst_insvc", bus.in_service, 0);
    chk("rst_id", bus.int_id, 0);
    rst_n = 1'b1;
    step(lvl, 0, 0, 0, 0, 1, 2'd0, 4'h0);
    lvl = 4'b0100; idle(1); serve();
    lvl = 4'b0000; idle(1);
    lvl = 4'b1011; idle(1); serve(); serve(); serve();
    lvl = 4'b0000; idle(1);
    lvl = 4'b1001; idle(1); serve(); serve();
    lvl = 4'b0000; idle(1);
    lvl = 4'b0010;
    repeat (5) step(lvl, 1, 0, 0, 0, 0, 2'd0, 4'h0);
    serve();
    lvl = 4'b0000; idle(1);
    step(4'b0001, 1, 0, 0, 0, 0, 2'd0, 4'h0);
    step(4'b0000, 1, 0, 0, 0, 0, 2'd0, 4'h0);
    step(4'b0001, 1, 0, 0, 0, 0, 2'd0, 4'h0);
    step(4'b0000, 1, 0, 0, 0, 1, 2'd1, 4'b0001);
    wait_ph(P_REQ);
    lvl = 4'b0001;
    step(lvl, 0, 0, 1, 0, 0, 2'd0, 4'h0);
    idle(1);
    step(lvl, 0, 0, 0, 1, 0, 2'd0, 4'h0);
    wait_ph(P_IDLE); serve();
    lvl = 4'b0000; idle(1);
    lvl = 4'b1000; wait_ph(P_REQ);
    step(lvl, 0, 0, 0, 0, 1, 2'd0, 4'b1000);
    idle(2); serve();
    lvl = 4'b0000; idle(1);
    lvl = 4'b1000; idle(6);
    step(lvl, 0, 0, 0, 0, 1, 2'd0, 4'h0);
    serve();
    lvl = 4'b0000; idle(1);
    lvl = 4'b0110; wait_ph(P_REQ);
    step(lvl, 0, 0, 1, 0, 0, 2'd0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_insvc", bus.in_service, 0);
    chk("arst_pending", bus.pending, 0);
    chk("arst_req", bus.int_req, 0);
    chk("arst_mask", bus.mask, 4'hf);
    model_reset();
    lvl = '0;
    drive(0, 0, 0, 0, 0, 0, 2'd0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(lvl, 0, 0, 0, 1, 0, 2'd0, 4'h0);
    step(lvl, 0, 0, 0, 0, 1, 2'd0, 4'h0);
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] tog;
      tog = 4'($urandom) & 4'($urandom) & 4'($urandom);
      lvl = lvl ^ tog;
      step(lvl, $urandom % 5 == 0, $urandom % 7 == 0,
           m_ph == P_REQ ? $urandom % 3 == 0 : $urandom % 25 == 0,
           m_ph == P_SVC ? $urandom % 4 == 0 : $urandom % 25 == 0,
           $urandom % 15 == 0, 2'($urandom), 4'($urandom) & 4'($urandom));
    end
    idle(2);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
